// File: rtl/alu_serial_ctrl.sv
// Bit-serial NOR/XOR/ADD/SUB sequencer: one shared alu1bit walks the operands
// LSB first, one bit per clock, behind a start/busy/done handshake.

module alu1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);
  logic b_eff;
  logic sum;
  logic maj;

  // SUB is a + ~b + 1; the +1 arrives through the carry chain seed.
  assign b_eff = b ^ (op[1] & op[0]);
  assign sum   = a ^ b_eff ^ cin;
  assign maj   = (a & b_eff) | (a & cin) | (b_eff & cin);

  always_comb begin
    s    = 1'b0;
    cout = 1'b0;
    case (op)
      2'b00:   s = ~(a | b);
      2'b01:   s = a ^ b;
      default: begin
        s    = sum;
        cout = maj;
      end
    endcase
  end
endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);
  // Handshake: start is a request sampled only in IDLE or DONE; an accepted
  // start raises busy for exactly WIDTH cycles, then done pulses for one cycle
  // with result/carry/zero valid. start while busy is dropped, never queued.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cff_q, cff_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             alu_s;
  logic             alu_cout;
  logic [WIDTH-1:0] final_res;
  logic             accept;

  alu1bit u_alu (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (cff_q),
    .op   (op_q),
    .s    (alu_s),
    .cout (alu_cout)
  );

  // The last bit is still on the ALU output when the result is committed.
  assign final_res = {alu_s, r_sh_q[WIDTH-1:1]};
  assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    cff_d    = cff_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;

    case (state_q)
      ST_RUN: begin
        r_sh_d = final_res;
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        cff_d  = alu_cout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d  = ST_DONE;
          result_d = final_res;
          carry_d  = op_q[1] & alu_cout;
          zero_d   = (final_res == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d = ST_RUN;
      a_sh_d  = a;
      b_sh_d  = b;
      op_d    = op;
      r_sh_d  = '0;
      cnt_d   = '0;
      cff_d   = op[1] & op[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      cff_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      cff_q    <= cff_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
Bit-serial sequencer that computes a WIDTH-bit NOR/XOR/ADD/SUB with one internal alu1bit instance, one bit per clock, LSB first. It holds the operand and result shift registers and the carry flip-flop, and runs a start/busy/done handshake toward the requesting logic. It sits between the control unit and the single-bit gate-level ALU and shares that one ALU across all bit positions over time.

Parameters:
WIDTH, 8, operand/result width in bits (≥2); sets cycle count and counter width ($clog2(WIDTH)+1).

Ports:
clk  input  1  system clock, rising edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE or DONE
op  input  2  00 NOR, 01 XOR, 10 ADD (a+b), 11 SUB (a-b); latched on accepted start
a  input  WIDTH  operand A; latched on accepted start
b  input  WIDTH  operand B; latched on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse, result/flags valid
result  output  WIDTH  last completed result; held until next completion
carry  output  1  ADD: carry out of MSB; SUB: no-borrow (1 iff a≥b unsigned); NOR/XOR: 0
zero  output  1  1 iff result==0; updated with result

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports clk and rst.
- Reset (any time, including mid-operation): state IDLE; busy=0, done=0, result=0, carry=0, zero=0; shift regs, counter, carry FF cleared. Operation in flight is abandoned; no done.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge k -> latch a, b, op; cnt=0; carry FF <= op[1]&op[0] (1 for SUB, 0 otherwise); go RUN.
  - RUN: busy=1. ALU inputs each cycle: a=a_sh[0], b=b_sh[0], cin=carry FF, op=latched op. At each edge: shift ALU s into result shift reg MSB (shift right); carry FF <= ALU cout; a_sh, b_sh shift right; cnt++. After edge with cnt==WIDTH-1 -> DONE.
  - DONE: one cycle; done=1, busy=0. Next edge: start=1 -> behave as IDLE accept (back-to-back op, RUN next); else IDLE.
- Latency: start sampled at edge k -> busy high cycles k+1..k+WIDTH; done high in cycle k+WIDTH+1; throughput one op per WIDTH+1 cycles.
- Outputs result/carry/zero update at the edge entering DONE, hold until next entry to DONE or reset. carry forced 0 for NOR/XOR (carry FF ignored). zero computed from final result register.
- start during RUN ignored, no queuing; a, b, op changes during RUN have no effect.
- Arithmetic modulo 2^WIDTH; no overflow flag.
- Timing: ALU inputs are registered and stable right after each edge; clock period must exceed alu1bit worst-case a/b/cin/op->s/cout propagation (bench uses period 100).

Test Plan:
- WIDTH=8, ADD a=0x5A b=0x3C -> busy 8 cycles, done at k+9, result=0x96, carry=0, zero=0.
- ADD a=0xFF b=0x01 -> result=0x00, carry=1, zero=1; then SUB a=0x10 b=0x01 with start in DONE cycle -> RUN immediately, result=0x0F, carry=1.
- SUB a=0x01 b=0x02 -> result=0xFF, carry=0 (borrow), zero=0.
- NOR a=0xF0 b=0x0C -> result=0x03, carry=0; XOR a=0xAA b=0xAA -> result=0x00, zero=1, carry=0.
- start pulsed with different a/op during RUN (cycle k+4) -> ignored, original result delivered at k+9, single done pulse.
- rst asserted asynchronously mid-RUN (cycle k+3, between edges) -> busy/done/result/carry/zero=0 immediately, state IDLE, no done; next start works normally.
